// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared state encoding and skid depth for the RAM burst controller
package ram_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/ram_rd_skid.sv
// ram_rd_skid: 2-entry read-return FIFO absorbing the RAM read latency under backpressure
module ram_rd_skid
    import ram_ctrl_pkg::*;
#(
    parameter int DWID = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  logic [DWID-1:0]                     push_data,
    input  logic                                pop,
    output logic [DWID-1:0]                     head,
    output logic                                valid,
    output logic [$clog2(SKID_DEPTH+1)-1:0]     count
);
    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = $clog2(SKID_DEPTH+1);

    logic [DWID-1:0] r_mem [SKID_DEPTH];
    logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]   r_count;

    assign head  = r_mem[r_rd_ptr];
    assign valid = r_count != '0;
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: turns burst commands plus write/read beat streams into single-beat RAM port accesses
module ram_burst_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AWID  = 8,
    parameter int DWID  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AWID-1:0] cmd_addr,
    input  logic [AWID:0]   cmd_len,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [DWID-1:0] wr_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [DWID-1:0] rd_data,
    output logic            busy,
    output logic            done,
    output logic            ram_we,
    output logic [AWID-1:0] ram_addr,
    output logic [DWID-1:0] ram_din,
    input  logic [DWID-1:0] ram_dout
);
    localparam int RW = $clog2(DEPTH) + 1;

    state_t                              r_state, w_next;
    logic [AWID-1:0]                     r_cur_addr, r_ram_addr;
    logic [RW-1:0]                       r_remaining;
    logic                                r_inflight;
    logic [$clog2(SKID_DEPTH+1)-1:0]     w_count;
    logic [2:0]                          w_occ;
    logic                                w_rem_nz, w_wr_acc, w_issue, w_pop, w_accept;

    assign w_rem_nz  = r_remaining != '0;
    assign w_accept  = cmd_valid && cmd_ready;
    assign cmd_ready = r_state == IDLE;
    assign busy      = r_state != IDLE;
    assign done      = r_state == FINISH;
    assign wr_ready  = r_state == WRITE && w_rem_nz && !rst;
    assign w_wr_acc  = wr_valid && wr_ready;
    assign ram_we    = w_wr_acc;
    assign ram_din   = wr_data;
    assign w_pop     = rd_valid && rd_ready;
    // Credit counts the slot freed by a same-cycle pop so reads stream at one beat per clock
    assign w_occ     = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue   = r_state == READ && w_rem_nz && w_occ < 3'd2;
    assign ram_addr  = (r_state == WRITE || w_issue) ? r_cur_addr : r_ram_addr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (cmd_valid) w_next = cmd_len == '0 ? FINISH : cmd_write ? WRITE : READ;
            WRITE:  if (w_wr_acc && r_remaining == RW'(1)) w_next = FINISH;
            READ:   if (!w_rem_nz && !r_inflight && (w_count == '0 || (w_count == 1 && w_pop))) w_next = FINISH;
            FINISH: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_ram_addr  <= '0;
        end else begin
            r_state    <= w_next;
            r_ram_addr <= ram_addr;
            r_inflight <= w_issue;
            if (w_accept) begin
                r_cur_addr  <= cmd_addr;
                r_remaining <= cmd_len;
            end else if (w_wr_acc || w_issue) begin
                r_cur_addr  <= r_cur_addr + AWID'(1);
                r_remaining <= r_remaining - RW'(1);
            end
        end
    end

    ram_rd_skid #(.DWID(DWID)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (ram_dout),
        .pop       (w_pop),
        .head      (rd_data),
        .valid     (rd_valid),
        .count     (w_count)
    );
endmodule
